// File: rtl/window_pkg.sv
// Shared constants and types for the 3x3 window generator.
// The window index constants are row-major: top row first, left to right.
package window_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int WIN_N     = 9;

  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  typedef logic [DEF_PIX_W-1:0] pixel_t;

endpackage

// File: rtl/line_buffer.sv
// One row of pixel history: a single read/write address, combinational read of
// the old contents and a write of the new value on the same edge (read-before-write).
module line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; the window valid flag hides stale rows.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 neighbourhood for the Sobel filter.
// Optional build macro WIN_POS_EN adds win_x/win_y centre-coordinate outputs.
module window_gen_3x3
  import window_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     refresh,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic [PIX_W-1:0]         win0,
  output logic [PIX_W-1:0]         win1,
  output logic [PIX_W-1:0]         win2,
  output logic [PIX_W-1:0]         win3,
  output logic [PIX_W-1:0]         win4,
  output logic [PIX_W-1:0]         win5,
  output logic [PIX_W-1:0]         win6,
  output logic [PIX_W-1:0]         win7,
  output logic [PIX_W-1:0]         win8,
`ifdef WIN_POS_EN
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y,
`endif
  output logic                     win_valid,
  output logic                     frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [PIX_W-1:0] win_q [WIN_N];
  logic [PIX_W-1:0] win_d [WIN_N];
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             accept;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
`ifdef WIN_POS_EN
  logic [XW-1:0]    win_x_q, win_x_d;
  logic [YW-1:0]    win_y_q, win_y_d;
`endif

  // refresh always wins over a coincident pixel
  assign accept = pix_valid & ~refresh;

  // lb0 holds row y-1; its old value cascades into lb1 (row y-2)
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (x_q),
    .wdata (pix_in),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (x_q),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef WIN_POS_EN
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
`endif
    if (refresh) begin
      x_d = '0;
      y_d = '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]     = win_q[r*3 + 1];
        win_d[r*3 + 1] = win_q[r*3 + 2];
      end
      win_d[WIN_TR] = lb1_rd;
      win_d[WIN_MR] = lb0_rd;
      win_d[WIN_BR] = pix_in;

      win_valid_d = (x_q >= XW'(2)) && (y_q >= YW'(2));
`ifdef WIN_POS_EN
      if (win_valid_d) begin
        win_x_d = x_q - XW'(1);
        win_y_d = y_q - YW'(1);
      end
`endif
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d          = '0;
          frame_done_d = 1'b1;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < WIN_N; k++) begin
        win_q[k] <= '0;
      end
`ifdef WIN_POS_EN
      win_x_q      <= '0;
      win_y_q      <= '0;
`endif
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
`ifdef WIN_POS_EN
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
`endif
    end
  end

  assign win0       = win_q[WIN_TL];
  assign win1       = win_q[WIN_TC];
  assign win2       = win_q[WIN_TR];
  assign win3       = win_q[WIN_ML];
  assign win4       = win_q[WIN_MC];
  assign win5       = win_q[WIN_MR];
  assign win6       = win_q[WIN_BL];
  assign win7       = win_q[WIN_BC];
  assign win8       = win_q[WIN_BR];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
`ifdef WIN_POS_EN
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 4x4 image; pixel ids are base+y*4+x.
// With WIN_POS_EN defined the centre coordinates are checked on every window.
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       refresh = 1'b0;
  logic [7:0] pix_in = 8'h00;
  logic       pix_valid = 1'b0;
  logic [7:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic       win_valid;
  logic       frame_done;
`ifdef WIN_POS_EN
  logic [1:0] win_x;
  logic [1:0] win_y;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] w [9];
  assign w[0] = win0;
  assign w[1] = win1;
  assign w[2] = win2;
  assign w[3] = win3;
  assign w[4] = win4;
  assign w[5] = win5;
  assign w[6] = win6;
  assign w[7] = win7;
  assign w[8] = win8;

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh    (refresh),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .win0       (win0),
    .win1       (win1),
    .win2       (win2),
    .win3       (win3),
    .win4       (win4),
    .win5       (win5),
    .win6       (win6),
    .win7       (win7),
    .win8       (win8),
`ifdef WIN_POS_EN
    .win_x      (win_x),
    .win_y      (win_y),
`endif
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied on the falling edge, outputs sampled 1 after the rising edge.
  task automatic drive(input logic [7:0] p, input logic v, input logic r, input logic rs);
    @(negedge clk);
    pix_in    = p;
    pix_valid = v;
    refresh   = r;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  // Expected window for centre (cx,cy): rows cy-1..cy+1, columns cx-1..cx+1.
  task automatic chk_win(input int base, input int cx, input int cy);
    logic [7:0] e;
    for (int k = 0; k < 9; k++) begin
      e = 8'(base + (cy - 1 + k / 3) * W + (cx - 1 + k % 3));
      chk($sformatf("win%0d@(%0d,%0d)", k, cx, cy), {24'd0, w[k]}, {24'd0, e});
    end
`ifdef WIN_POS_EN
    chk("win_x", {30'd0, win_x}, cx);
    chk("win_y", {30'd0, win_y}, cy);
`endif
  endtask

  // Sends the first n pixels of a frame starting at (0,0), optionally with an idle
  // cycle after each pixel, and checks every window and flag along the way.
  task automatic send_seq(input int base, input int n, input bit gaps, input int exp_wins);
    int         x, y, seen;
    logic [7:0] hold [9];
    seen = 0;
    for (int i = 0; i < n; i++) begin
      x = i % W;
      y = i / W;
      drive(8'(base + i), 1'b1, 1'b0, 1'b0);
      if (win_valid === 1'b1) seen++;
      chk($sformatf("win_valid@(%0d,%0d)", x, y), {31'd0, win_valid}, (x >= 2 && y >= 2) ? 1 : 0);
      chk($sformatf("frame_done@(%0d,%0d)", x, y), {31'd0, frame_done}, (x == W-1 && y == H-1) ? 1 : 0);
      if (x >= 2 && y >= 2) chk_win(base, x - 1, y - 1);
      if (gaps) begin
        for (int k = 0; k < 9; k++) hold[k] = w[k];
        drive(8'hEE, 1'b0, 1'b0, 1'b0);
        chk("gap_win_valid", {31'd0, win_valid}, 0);
        chk("gap_frame_done", {31'd0, frame_done}, 0);
        for (int k = 0; k < 9; k++) chk($sformatf("gap_hold%0d", k), {24'd0, w[k]}, {24'd0, hold[k]});
      end
    end
    chk("window_count", seen, exp_wins);
  endtask

  initial begin
    // reset with a valid pixel present: nothing must be accepted
    drive(8'h77, 1'b1, 1'b0, 1'b1);
    drive(8'h78, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) chk($sformatf("rst_win%0d", k), {24'd0, w[k]}, 0);
    chk("rst_win_valid", {31'd0, win_valid}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
`ifdef WIN_POS_EN
    chk("rst_win_x", {30'd0, win_x}, 0);
    chk("rst_win_y", {30'd0, win_y}, 0);
`endif

    // 1: continuous frame
    send_seq(0, 16, 1'b0, 4);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    chk("idle_frame_done", {31'd0, frame_done}, 0);
    chk("idle_win_valid", {31'd0, win_valid}, 0);
    chk("last_win0", {24'd0, win0}, 5);
    chk("last_win8", {24'd0, win8}, 15);

    // 2: same frame with idle cycles between pixels
    send_seq(0, 16, 1'b1, 4);

    // 3: back-to-back frames, the second with distinct ids
    send_seq(0, 16, 1'b0, 4);
    send_seq(100, 16, 1'b0, 4);
    chk("f2_first_pix_in_last_win", {24'd0, win4}, 110);

    // 4: refresh after pixel 7, then a fresh frame
    send_seq(200, 8, 1'b0, 0);
    drive(8'h00, 1'b0, 1'b1, 1'b0);
    chk("refresh_win_valid", {31'd0, win_valid}, 0);
    chk("refresh_frame_done", {31'd0, frame_done}, 0);
    send_seq(50, 16, 1'b0, 4);

    // 5: refresh together with pixel (2,2)
    send_seq(30, 10, 1'b0, 0);
    drive(8'd40, 1'b1, 1'b1, 1'b0);
    chk("drop_win_valid", {31'd0, win_valid}, 0);
    send_seq(70, 16, 1'b0, 4);

    // reset mid-frame after one window has been produced
    send_seq(0, 11, 1'b0, 1);
    drive(8'h55, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) chk($sformatf("midrst_win%0d", k), {24'd0, w[k]}, 0);
    chk("midrst_win_valid", {31'd0, win_valid}, 0);
    chk("midrst_frame_done", {31'd0, frame_done}, 0);
`ifdef WIN_POS_EN
    chk("midrst_win_x", {30'd0, win_x}, 0);
    chk("midrst_win_y", {30'd0, win_y}, 0);
`endif
    send_seq(90, 16, 1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
